cache_mem_ctrl: RTL and testbench

Memory-side responder for the cache request protocol. Accepts word requests from the instruction cache (iREN/iaddr) and the data cache (dREN/dWEN/daddr/dstore), arbitrates with data-side priority plus an instruction anti-starvation override, drives the single-port RAM, and returns iwait/dwait and load data. Sits between the two caches and the RAM model, on the far side of the caches' iwait/dwait handshake.

---
 rtl/cache_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_cache_mem_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for the icache/dcache request protocol: arbitrates the two caches onto a
// single-port RAM, with data-side priority, block-pair locking and an instruction anti-starvation override.
module cache_mem_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache side
  input  logic        iREN_i,
  input  logic [31:0] iaddr_i,
  output logic        iwait_o,
  output logic [31:0] iload_o,
  // dcache side
  input  logic        dREN_i,
  input  logic        dWEN_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dstore_i,
  output logic        dwait_o,
  output logic [31:0] dload_o,
  // RAM side
  output logic        ramREN_o,
  output logic        ramWEN_o,
  output logic [31:0] ramaddr_o,
  output logic [31:0] ramstore_o,
  input  logic [31:0] ramload_i,
  input  logic [1:0]  ramstate_i,
  output logic        ram_err_o
);

  localparam int unsigned StW = ($clog2(STARVE_LIMIT + 1) < 3) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIMIT);
  localparam logic [7:0]     ToMax     = 8'(TIMEOUT);

  localparam logic [1:0] RamAccess = 2'b10;
  localparam logic [1:0] RamError  = 2'b11;

  typedef enum logic [1:0] {StIdle, StDgnt, StIgnt} state_e;

  state_e         state_q, state_d;
  logic [StW-1:0] starve_q, starve_d;
  logic [7:0]     to_q, to_d;
  logic           err_q, err_d;
  logic           d_req;

  assign d_req     = dREN_i | dWEN_i;
  assign ram_err_o = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      starve_q <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      to_q     <= to_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    to_d       = to_q;
    err_d      = err_q;
    iwait_o    = 1'b1;
    dwait_o    = 1'b1;
    iload_o    = '0;
    dload_o    = '0;
    ramREN_o   = 1'b0;
    ramWEN_o   = 1'b0;
    ramaddr_o  = '0;
    ramstore_o = '0;

    unique case (state_q)
      StIdle: begin
        to_d = '0;
        if (iREN_i && (starve_q == StarveMax)) begin
          state_d  = StIgnt;
          starve_d = '0;
        end else if (d_req) begin
          state_d = StDgnt;
        end else if (iREN_i) begin
          state_d  = StIgnt;
          starve_d = '0;
        end
      end

      StDgnt: begin
        if (!d_req) begin
          state_d = StIdle;
        end else begin
          ramaddr_o  = daddr_i;
          ramstore_o = dstore_i;
          ramWEN_o   = dWEN_i;
          ramREN_o   = dREN_i & ~dWEN_i;
          if (ramstate_i == RamAccess) begin
            dwait_o = 1'b0;
            dload_o = dWEN_i ? '0 : ramload_i;
            to_d    = '0;
            if (iREN_i && (starve_q != StarveMax)) starve_d = starve_q + 1'b1;
            // First word of a block pair keeps the grant so the icache cannot slip in between.
            if (daddr_i[2]) state_d = StIdle;
          end else if (ramstate_i == RamError || to_q == ToMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end

      StIgnt: begin
        if (!iREN_i) begin
          state_d = StIdle;
        end else begin
          ramaddr_o = iaddr_i;
          ramREN_o  = 1'b1;
          if (ramstate_i == RamAccess) begin
            iwait_o = 1'b0;
            iload_o = ramload_i;
            to_d    = '0;
            state_d = StIdle;
          end else if (ramstate_i == RamError || to_q == ToMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed self-checking bench for cache_mem_ctrl: arbitration, block locking, starvation override,
// timeout, RAM error and reset behaviour.
module tb_cache_mem_ctrl;

  localparam logic [1:0] Free   = 2'b00;
  localparam logic [1:0] Busy   = 2'b01;
  localparam logic [1:0] Access = 2'b10;
  localparam logic [1:0] Error  = 2'b11;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramren, ramwen, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_pass   = 0;
  bit both_low = 1'b0;

  cache_mem_ctrl #(.STARVE_LIMIT(4), .TIMEOUT(255)) u_dut (
    .CLK        (clk),
    .nRST       (n_rst),
    .iREN_i     (iren),
    .iaddr_i    (iaddr),
    .iwait_o    (iwait),
    .iload_o    (iload),
    .dREN_i     (dren),
    .dWEN_i     (dwen),
    .daddr_i    (daddr),
    .dstore_i   (dstore),
    .dwait_o    (dwait),
    .dload_o    (dload),
    .ramREN_o   (ramren),
    .ramWEN_o   (ramwen),
    .ramaddr_o  (ramaddr),
    .ramstore_o (ramstore),
    .ramload_i  (ramload),
    .ramstate_i (ramstate),
    .ram_err_o  (ram_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!iwait && !dwait) both_low = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {iwait, dwait, ramREN, ramWEN} at their idle values
  task automatic check_idle(input string tag);
    check(tag, {28'd0, iwait, dwait, ramren, ramwen}, 32'hC);
  endtask

  initial begin
    int n;
    bit saw_done;

    n_rst = 1'b0; iren = 0; dren = 0; dwen = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = Free;
    #2;
    check_idle("reset_outputs");
    check("reset_err", {31'd0, ram_err}, 32'd0);
    check("reset_ramaddr", ramaddr, 32'd0);
    repeat (2) tick();
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      check("idle_5", {27'd0, iwait, dwait, ramren, ramwen, ram_err}, 32'h18);
    end

    // icache read, two BUSY then ACCESS
    tick(); iren = 1; iaddr = 32'h40; ramstate = Busy; #2;
    check("i_arb_cycle_ren", {31'd0, ramren}, 32'd0);
    tick(); #2;
    check("i_busy1_ren", {31'd0, ramren}, 32'd1);
    check("i_busy1_addr", ramaddr, 32'h40);
    check("i_busy1_iwait", {31'd0, iwait}, 32'd1);
    tick(); #2;
    check("i_busy2_ren", {31'd0, ramren}, 32'd1);
    tick(); ramstate = Access; ramload = 32'hDEADBEEF; #2;
    check("i_acc_ren", {31'd0, ramren}, 32'd1);
    check("i_acc_iwait", {31'd0, iwait}, 32'd0);
    check("i_acc_iload", iload, 32'hDEADBEEF);
    check("i_acc_dwait", {31'd0, dwait}, 32'd1);
    tick(); iren = 0; ramstate = Free; #2;
    check_idle("i_done_idle");
    check("i_done_iload", iload, 32'd0);

    // dcache block write with iREN held; ACCESS immediate
    tick(); iren = 1; iaddr = 32'h80; dwen = 1; daddr = 32'h3100; dstore = 32'h11111111;
    ramstate = Access; ramload = 32'h77777777; #2;
    check_idle("bw_arb_idle");
    tick(); #2;
    check("bw_w0_addr", ramaddr, 32'h3100);
    check("bw_w0_strobes", {30'd0, ramwen, ramren}, 32'h2);
    check("bw_w0_store", ramstore, 32'h11111111);
    check("bw_w0_dwait", {31'd0, dwait}, 32'd0);
    check("bw_w0_dload", dload, 32'd0);
    check("bw_w0_iwait", {31'd0, iwait}, 32'd1);
    tick(); daddr = 32'h3104; dstore = 32'h22222222; #2;
    check("bw_w1_addr", ramaddr, 32'h3104);
    check("bw_w1_wen", {31'd0, ramwen}, 32'd1);
    check("bw_w1_dwait", {31'd0, dwait}, 32'd0);
    check("bw_w1_iwait", {31'd0, iwait}, 32'd1);
    tick(); dwen = 0; #2;
    check_idle("bw_idle_after");
    tick(); ramload = 32'hCAFEF00D; #2;
    check("bw_ignt_addr", ramaddr, 32'h80);
    check("bw_ignt_iwait", {31'd0, iwait}, 32'd0);
    check("bw_ignt_iload", iload, 32'hCAFEF00D);
    tick(); iren = 0; #2;
    check_idle("bw_end_idle");

    // starvation: iREN held through two block reads, then I must win over dREN
    tick(); iren = 1; iaddr = 32'h100; dren = 1; daddr = 32'h200; ramload = 32'h0A0A0A0A; #2;
    check_idle("st_arb0");
    tick(); #2;
    check("st_d0_addr", ramaddr, 32'h200);
    check("st_d0_dload", dload, 32'h0A0A0A0A);
    tick(); daddr = 32'h204; #2;
    check("st_d1_dwait", {31'd0, dwait}, 32'd0);
    tick(); daddr = 32'h208; #2;
    check_idle("st_arb1");
    tick(); #2;
    check("st_d2_addr", ramaddr, 32'h208);
    tick(); daddr = 32'h20C; #2;
    check("st_d3_dwait", {31'd0, dwait}, 32'd0);
    tick(); daddr = 32'h214; #2;
    check_idle("st_arb2");
    tick(); #2;
    check("st_i_wins_addr", ramaddr, 32'h100);
    check("st_i_wins_iwait", {31'd0, iwait}, 32'd0);
    check("st_i_wins_dwait", {31'd0, dwait}, 32'd1);
    tick(); #2;
    check_idle("st_arb3");
    tick(); #2;
    check("st_cleared_addr", ramaddr, 32'h214);
    check("st_cleared_dwait", {31'd0, dwait}, 32'd0);
    tick(); iren = 0; dren = 0; ramstate = Free; #2;
    check_idle("st_end_idle");

    // request dropped mid-grant
    tick(); dren = 1; daddr = 32'h400; ramstate = Busy; #2;
    tick(); #2;
    check("drop_grant_ren", {31'd0, ramren}, 32'd1);
    tick(); dren = 0; #2;
    check("drop_ren_now", {31'd0, ramren}, 32'd0);
    check("drop_dwait", {31'd0, dwait}, 32'd1);

    // timeout with RAM stuck BUSY
    tick(); dren = 1; daddr = 32'h300; ramstate = Busy; #2;
    n = 0; saw_done = 1'b0;
    tick(); #2;
    while (!ram_err && n < 400) begin
      if (!dwait) saw_done = 1'b1;
      if (ramren) n++;
      tick(); #2;
    end
    check("to_grant_cycles", n, 32'd256);
    check("to_err_set", {31'd0, ram_err}, 32'd1);
    check("to_no_completion", {31'd0, saw_done}, 32'd0);
    check_idle("to_back_idle");
    tick(); dren = 0; ramstate = Free; #2;
    tick(); #2;
    check("to_err_sticky", {31'd0, ram_err}, 32'd1);

    // reset in the middle of an icache grant
    tick(); iren = 1; iaddr = 32'h600; ramstate = Busy; #2;
    tick(); #2;
    check("rst_mid_pre_ren", {31'd0, ramren}, 32'd1);
    #1; n_rst = 1'b0; #1;
    check_idle("rst_mid_idle");
    check("rst_mid_err", {31'd0, ram_err}, 32'd0);
    iren = 0;
    tick(); n_rst = 1'b1; #2;
    check_idle("rst_release_idle");

    // RAM ERROR during IGNT, then a normal retry
    tick(); iren = 1; iaddr = 32'h500; ramstate = Busy; #2;
    tick(); ramstate = Error; #2;
    check("err_ren", {31'd0, ramren}, 32'd1);
    check("err_iwait", {31'd0, iwait}, 32'd1);
    tick(); ramstate = Free; #2;
    check("err_flag", {31'd0, ram_err}, 32'd1);
    check_idle("err_idle");
    tick(); ramstate = Access; ramload = 32'h5A5A5A5A; #2;
    check("err_retry_addr", ramaddr, 32'h500);
    check("err_retry_iwait", {31'd0, iwait}, 32'd0);
    check("err_retry_iload", iload, 32'h5A5A5A5A);
    tick(); iren = 0; ramstate = Free; #2;
    check_idle("err_end_idle");

    check("never_both_waits_low", {31'd0, both_low}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
